iir_one_pole_filter: RTL



---
 rtl/iir_one_pole_filter_if.sv | 26 ++
 rtl/iir_one_pole_filter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/iir_one_pole_filter_if.sv
// rtl/iir_one_pole_filter_if.sv - frame/handshake bundle between audio source, one-pole IIR filter and sink
interface iir_one_pole_filter_if #(
    parameter int SAMPLE_W = 16,
    parameter int NUM_CH   = 2,
    parameter int COEF_W   = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_CH*SAMPLE_W-1:0] in_data;
    logic [COEF_W-1:0]          coef;
    logic [1:0]                 mode;
    logic                       clr;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_CH*SAMPLE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, coef, mode, clr, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, coef, mode, clr, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iir_one_pole_filter.sv
// rtl/iir_one_pole_filter.sv - one-pole IIR audio filter, channels time-shared on one multiplier; IIR_CLIP_FLAG_EN adds sticky HPF clip flags
module iir_one_pole_filter #(
    parameter int SAMPLE_W = 16,
    parameter int NUM_CH   = 2,
    parameter int COEF_W   = 16
) (
    input  logic clk,
    input  logic rst,
    iir_one_pole_filter_if.slave bus
`ifdef IIR_CLIP_FLAG_EN
    ,
    output logic [NUM_CH-1:0] clip_flag
`endif
);

    // acc is Q.COEF_W; d needs one extra bit because x and acc may sit at opposite rails
    localparam int AW   = SAMPLE_W + COEF_W + 1;
    localparam int DW   = AW + 1;
    localparam int PW   = DW + COEF_W + 1;
    localparam int XP   = DW - SAMPLE_W - COEF_W;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] MODE_BYP  = 2'b00;
    localparam logic [1:0] MODE_LPF  = 2'b01;
    localparam logic [1:0] MODE_HPF  = 2'b10;

    localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic                       in_ready_c;
    logic                       accept;
    logic                       last_ch;

    logic [NUM_CH*SAMPLE_W-1:0] frame_q;
    logic [NUM_CH*SAMPLE_W-1:0] out_q;
    logic [COEF_W-1:0]          coef_q;
    logic [1:0]                 mode_q;
    logic [CH_W-1:0]            ch_q;
    logic                       out_valid_q;
    logic signed [AW-1:0]       acc_q [NUM_CH];

    int                         slot;
    logic signed [SAMPLE_W-1:0] x_cur;
    logic signed [AW-1:0]       acc_cur;
    logic signed [DW-1:0]       x_ext;
    logic signed [DW-1:0]       d;
    logic signed [COEF_W:0]     coef_s;
    logic signed [PW-1:0]       prod;
    logic signed [AW-1:0]       acc_new;
    logic signed [SAMPLE_W-1:0] y_lp;
    logic signed [SAMPLE_W:0]   hp_full;
    logic signed [SAMPLE_W-1:0] hp_val;
    logic                       hp_sat;
    logic signed [SAMPLE_W-1:0] y_sel;
    logic                       unused_prod_bits;

    // next-state and input-ready decode
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = S_CALC;
            end
            S_CALC: begin
                if (last_ch) state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ready is held low while reset is asserted even though the FSM already sits in IDLE
    assign bus.in_ready  = in_ready_c & rst;
    assign accept        = in_ready_c & bus.in_valid;
    assign last_ch       = (ch_q == CH_W'(NUM_CH - 1));
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // shared datapath for the channel selected by ch_q; channel 0 lives in the top slot
    always_comb begin
        slot    = NUM_CH - 1 - int'(ch_q);
        x_cur   = frame_q[slot*SAMPLE_W +: SAMPLE_W];
        acc_cur = acc_q[ch_q];
        x_ext   = {{XP{x_cur[SAMPLE_W-1]}}, x_cur, {COEF_W{1'b0}}};
        d       = x_ext - {acc_cur[AW-1], acc_cur};
        coef_s  = {1'b0, coef_q};
        prod    = PW'(d) * PW'(coef_s);
        acc_new = acc_cur + prod[COEF_W +: AW];
        y_lp    = acc_new[COEF_W +: SAMPLE_W];
        hp_full = {x_cur[SAMPLE_W-1], x_cur} - {y_lp[SAMPLE_W-1], y_lp};
        hp_sat  = hp_full[SAMPLE_W] != hp_full[SAMPLE_W-1];
        if (!hp_sat)                hp_val = hp_full[SAMPLE_W-1:0];
        else if (hp_full[SAMPLE_W]) hp_val = SAT_MIN;
        else                        hp_val = SAT_MAX;
        case (mode_q)
            MODE_BYP: y_sel = x_cur;
            MODE_LPF: y_sel = y_lp;
            MODE_HPF: y_sel = hp_val;
            default:  y_sel = '0;
        endcase
    end

    assign unused_prod_bits = ^{prod[COEF_W-1:0], prod[PW-1:COEF_W+AW]};

    // frame capture, channel sequencing and output holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q     <= '0;
            coef_q      <= '0;
            mode_q      <= MODE_BYP;
            ch_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                frame_q <= bus.in_data;
                coef_q  <= bus.coef;
                mode_q  <= bus.mode;
                ch_q    <= '0;
            end
            if (state_q == S_CALC) begin
                out_q[slot*SAMPLE_W +: SAMPLE_W] <= y_sel;
                ch_q <= last_ch ? '0 : ch_q + 1'b1;
            end
            out_valid_q <= (state_d == S_OUT);
        end
    end

    // per-channel filter state; clr overrides the update of the channel computed on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else if (bus.clr) begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
        end else if (state_q == S_CALC) begin
            acc_q[ch_q] <= acc_new;
        end
    end

`ifdef IIR_CLIP_FLAG_EN
    logic [NUM_CH-1:0] clip_q;

    // sticky saturation flags laid out like the frame (channel 0 in the MSB); clr beats a coincident set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clip_q <= '0;
        end else if (bus.clr) begin
            clip_q <= '0;
        end else if (state_q == S_CALC && mode_q == MODE_HPF && hp_sat) begin
            clip_q[slot] <= 1'b1;
        end
    end

    assign clip_flag = clip_q;
`endif

endmodule
